// File: rtl/serv_rf_serdes.sv
// Register-file serdes for SERV: reads rs1/rs2 as words and streams them LSB-first,
// while gathering the serial rd result and writing it back as one word.
module serv_rf_serdes #(
    parameter int rf_l2d = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rreq,
    input  logic [rf_l2d-1:0] i_rreg0,
    input  logic [rf_l2d-1:0] i_rreg1,
    input  logic [rf_l2d-1:0] i_wreg0,
    input  logic              i_wen0,
    input  logic              i_wdata0,
    output logic              o_ready,
    output logic              o_busy,
    output logic              o_rdata0,
    output logic              o_rdata1,
    output logic [rf_l2d-1:0] o_rf_raddr,
    output logic              o_rf_ren,
    input  logic [31:0]       i_rf_rdata,
    output logic [rf_l2d-1:0] o_rf_waddr,
    output logic [31:0]       o_rf_wdata,
    output logic              o_rf_wen
);

    // state  | meaning
    // IDLE   | waiting for i_rreq
    // RD0    | word read of rs1
    // RD1    | word read of rs2, rs1 word captured
    // CAP    | rs2 word captured, bit counter cleared
    // STREAM | 32 cycles of serial rs1/rs2 out, rd in
    // WR     | rd word written back
    typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, STREAM, WR} state_t;

    state_t state, next_state;

    logic [rf_l2d-1:0] rreg0, rreg1, wreg0;
    logic              wen0;
    logic [31:0]       s0, s1, w;
    logic [4:0]        cnt;
    logic [rf_l2d-1:0] raddr_q, waddr_q;
    logic [31:0]       wdata_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (i_rreq) next_state = RD0;
            RD0:     next_state = RD1;
            RD1:     next_state = CAP;
            CAP:     next_state = STREAM;
            STREAM:  if (cnt == 5'd31) next_state = WR;
            WR:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rreg0   <= '0;
            rreg1   <= '0;
            wreg0   <= '0;
            wen0    <= 1'b0;
            s0      <= '0;
            s1      <= '0;
            w       <= '0;
            cnt     <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (i_rreq) begin
                    rreg0   <= i_rreg0;
                    rreg1   <= i_rreg1;
                    wreg0   <= i_wreg0;
                    wen0    <= i_wen0;
                    raddr_q <= i_rreg0;
                end
                RD0: raddr_q <= rreg1;
                RD1: s0 <= (rreg0 == '0) ? '0 : i_rf_rdata;
                CAP: begin
                    s1  <= (rreg1 == '0) ? '0 : i_rf_rdata;
                    cnt <= '0;
                end
                STREAM: begin
                    s0  <= {1'b0, s0[31:1]};
                    s1  <= {1'b0, s1[31:1]};
                    w   <= {i_wdata0, w[31:1]};
                    cnt <= cnt + 5'd1;
                    // The last serial bit lands in the same edge that loads the write word
                    if (cnt == 5'd31) begin
                        waddr_q <= wreg0;
                        wdata_q <= {i_wdata0, w[31:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_ready  = 1'b0;
        o_busy   = (state != IDLE);
        o_rdata0 = 1'b0;
        o_rdata1 = 1'b0;
        o_rf_ren = 1'b0;
        o_rf_wen = 1'b0;
        case (state)
            RD0, RD1: o_rf_ren = 1'b1;
            STREAM: begin
                o_rdata0 = s0[0];
                o_rdata1 = s1[0];
                o_ready  = (cnt == 5'd0);
            end
            WR:      o_rf_wen = wen0 & (wreg0 != '0);
            default: ;
        endcase
    end

    assign o_rf_raddr = raddr_q;
    assign o_rf_waddr = waddr_q;
    assign o_rf_wdata = wdata_q;

endmodule

// File: tb/tb_serv_rf_serdes.sv
// Directed and random bench for serv_rf_serdes with a behavioural word SRAM
// and a separate reference register model.
module tb_serv_rf_serdes;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rreq = 1'b0;
    logic [4:0]  rreg0 = '0, rreg1 = '0, wreg0 = '0;
    logic        wen0 = 1'b0, wdata0 = 1'b0;
    logic        ready, busy, rdata0, rdata1, ren, wen;
    logic [4:0]  raddr, waddr;
    logic [31:0] wdata, ram_rdata;

    logic [31:0] mem [32];
    logic [31:0] ref_rf [32];
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serv_rf_serdes #(.rf_l2d(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rreq(rreq),
        .i_rreg0(rreg0), .i_rreg1(rreg1), .i_wreg0(wreg0),
        .i_wen0(wen0), .i_wdata0(wdata0),
        .o_ready(ready), .o_busy(busy), .o_rdata0(rdata0), .o_rdata1(rdata1),
        .o_rf_raddr(raddr), .o_rf_ren(ren), .i_rf_rdata(ram_rdata),
        .o_rf_waddr(waddr), .o_rf_wdata(wdata), .o_rf_wen(wen)
    );

    // Behavioural SRAM: one-cycle read latency
    always @(posedge clk) begin
        if (ren) ram_rdata <= mem[raddr];
        if (wen) mem[waddr] <= wdata;
    end

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check_w(name, {31'b0, act}, {31'b0, exp});
    endtask

    always @(negedge clk) begin
        check_b("ren_wen_exclusive", ren & wen, 1'b0);
    end

    // Starts in an IDLE cycle (cycle 0) and ends in cycle 37, back in IDLE.
    task automatic run_txn(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] wr,
                           input logic we, input logic [31:0] wd,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic ewen, input logic noise);
        check_b("idle_busy", busy, 1'b0);
        rreq = 1'b1; rreg0 = r0; rreg1 = r1; wreg0 = wr; wen0 = we;
        @(negedge clk);
        rreq = 1'b0; rreg0 = ~r0; rreg1 = ~r1; wreg0 = ~wr; wen0 = ~we;
        check_b("rd0_ren", ren, 1'b1);
        check_w("rd0_raddr", {27'b0, raddr}, {27'b0, r0});
        check_b("rd0_busy", busy, 1'b1);
        @(negedge clk);
        check_b("rd1_ren", ren, 1'b1);
        check_w("rd1_raddr", {27'b0, raddr}, {27'b0, r1});
        @(negedge clk);
        check_b("cap_ren", ren, 1'b0);
        check_b("cap_rdata0", rdata0, 1'b0);
        check_b("cap_busy", busy, 1'b1);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            wdata0 = wd[k];
            rreq = noise && (k == 6);
            check_b("stream_rdata0", rdata0, e0[k]);
            check_b("stream_rdata1", rdata1, e1[k]);
            check_b("stream_ready", ready, k == 0);
            check_b("stream_busy", busy, 1'b1);
        end
        @(negedge clk);
        rreq = noise;
        wdata0 = 1'b0;
        check_b("wr_wen", wen, ewen);
        check_b("wr_busy", busy, 1'b1);
        if (ewen) begin
            check_w("wr_waddr", {27'b0, waddr}, {27'b0, wr});
            check_w("wr_wdata", wdata, wd);
        end
        @(negedge clk);
        rreq = 1'b0;
        check_b("end_busy", busy, 1'b0);
        check_b("end_wen", wen, 1'b0);
    endtask

    typedef struct {
        logic [4:0]  r0, r1, wr;
        logic        we;
        logic [31:0] wd, e0, e1;
        logic        ewen, noise;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [4:0]  r0, r1, wr;
        logic        we;
        logic [31:0] wd;

        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[0] = 32'hFFFF_FFFF;
        mem[5] = 32'hA5A5_0F0F;
        mem[6] = 32'h1234_5678;
        ram_rdata = '0;

        vecs[0] = '{5'd5, 5'd6, 5'd7, 1'b0, 32'h0000_0000, 32'hA5A5_0F0F, 32'h1234_5678, 1'b0, 1'b0};
        vecs[1] = '{5'd5, 5'd6, 5'd7, 1'b1, 32'hDEAD_BEEF, 32'hA5A5_0F0F, 32'h1234_5678, 1'b1, 1'b0};
        vecs[2] = '{5'd7, 5'd5, 5'd3, 1'b0, 32'h5555_AAAA, 32'hDEAD_BEEF, 32'hA5A5_0F0F, 1'b0, 1'b1};
        vecs[3] = '{5'd0, 5'd6, 5'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0};
        vecs[4] = '{5'd6, 5'd0, 5'd6, 1'b1, 32'h0F0F_A5A5, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5] = '{5'd6, 5'd6, 5'd9, 1'b0, 32'h0000_0000, 32'h0F0F_A5A5, 32'h0F0F_A5A5, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check_b("rst_busy", busy, 1'b0);
        check_b("rst_ready", ready, 1'b0);
        check_b("rst_ren", ren, 1'b0);
        check_b("rst_wen", wen, 1'b0);
        check_b("rst_rdata0", rdata0, 1'b0);
        check_b("rst_rdata1", rdata1, 1'b0);
        check_w("rst_raddr", {27'b0, raddr}, 32'h0);
        check_w("rst_waddr", {27'b0, waddr}, 32'h0);
        check_w("rst_wdata", wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table runs back to back: each start lands in cycle 37 of the previous one
        for (int i = 0; i < 6; i++)
            run_txn(vecs[i].r0, vecs[i].r1, vecs[i].wr, vecs[i].we, vecs[i].wd,
                    vecs[i].e0, vecs[i].e1, vecs[i].ewen, vecs[i].noise);

        // Reset in cycle 20 of a write transaction to x3
        @(negedge clk);
        rreq = 1'b1; rreg0 = 5'd5; rreg1 = 5'd6; wreg0 = 5'd3; wen0 = 1'b1;
        @(negedge clk);
        rreq = 1'b0;
        wdata0 = 1'b1;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_b("arst_busy", busy, 1'b0);
        check_b("arst_ready", ready, 1'b0);
        check_b("arst_ren", ren, 1'b0);
        check_b("arst_wen", wen, 1'b0);
        check_b("arst_rdata0", rdata0, 1'b0);
        check_b("arst_rdata1", rdata1, 1'b0);
        check_w("arst_raddr", {27'b0, raddr}, 32'h0);
        check_w("arst_waddr", {27'b0, waddr}, 32'h0);
        check_w("arst_wdata", wdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wdata0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_b("post_rst_wen", wen, 1'b0);
            check_b("post_rst_busy", busy, 1'b0);
        end
        run_txn(5'd3, 5'd5, 5'd0, 1'b0, 32'h0, 32'h0, 32'hA5A5_0F0F, 1'b0, 1'b0);

        // Reference model state after the directed part
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        ref_rf[5] = 32'hA5A5_0F0F;
        ref_rf[6] = 32'h0F0F_A5A5;
        ref_rf[7] = 32'hDEAD_BEEF;

        for (int t = 0; t < 14; t++) begin
            r0 = 5'($urandom_range(0, 31));
            r1 = 5'($urandom_range(0, 31));
            wr = (t % 3 == 0) ? r0 : 5'($urandom_range(0, 31));
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            run_txn(r0, r1, wr, we, wd, ref_rf[r0], ref_rf[r1], we && (wr != 5'd0), 1'b0);
            if (we && wr != 5'd0) ref_rf[wr] = wd;
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
